// File: rtl/iosi_lsu.sv
// iosi_lsu: load/store unit between execute and writeback.
// Accepts one request at a time, steers bytes onto an XLEN-wide memory
// port with valid/ready handshakes, and returns extended load data or an
// error code (misaligned/illegal, bus error, timeout).
`timescale 1ns/1ps
module iosi_lsu #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_is_store,
  input  logic [2:0]          load_sel,
  input  logic [1:0]          store_sel,
  input  logic [XLEN-1:0]     req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  input  logic [4:0]          req_rd,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [4:0]          resp_rd,
  output logic [XLEN-1:0]     resp_data,
  output logic                resp_err,
  output logic [1:0]          resp_err_code,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_we,
  output logic [XLEN-1:0]     mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_be,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata,
  input  logic                mem_rerr
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_ILL  = 2'b01;
  localparam logic [1:0] ERR_BUS  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Access size code: 00 byte, 01 half, 10 word, 11 double.
  function automatic logic [1:0] access_size(input logic       is_store,
                                             input logic [2:0] lsel,
                                             input logic [1:0] ssel);
    return is_store ? ssel : lsel[1:0];
  endfunction

  // Misaligned addresses, undefined load encodings and 64-bit ops on a
  // 32-bit datapath never reach memory.
  function automatic logic is_illegal(input logic       is_store,
                                      input logic [2:0] lsel,
                                      input logic [1:0] ssel,
                                      input logic [2:0] alow);
    logic [1:0] sz;
    logic       misal;
    logic       wide_op;
    sz = access_size(is_store, lsel, ssel);
    case (sz)
      2'b00:   misal = 1'b0;
      2'b01:   misal = alow[0];
      2'b10:   misal = |alow[1:0];
      2'b11:   misal = |alow[2:0];
      default: misal = 1'b1;
    endcase
    wide_op = (sz == 2'b11) || (!is_store && (lsel == 3'b110));
    return misal || (!is_store && (lsel == 3'b111)) || ((XLEN == 32) && wide_op);
  endfunction

  // Byte-enable mask for the access size, shifted into the addressed lane.
  function automatic logic [NB-1:0] lane_mask(input logic [1:0]    sz,
                                              input logic [OW-1:0] off);
    logic [7:0]    m;
    logic [NB-1:0] mm;
    case (sz)
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      2'b10:   m = 8'h0F;
      2'b11:   m = 8'hFF;
      default: m = 8'h00;
    endcase
    mm = NB'(m);
    return mm << off;
  endfunction

  // Replicate the low byte/half/word across the whole bus so any lane
  // selected by the byte enables carries the right data.
  function automatic logic [XLEN-1:0] replicate(input logic [1:0]      sz,
                                                input logic [XLEN-1:0] d);
    logic [XLEN-1:0] r;
    case (sz)
      2'b00:   r = {NB{d[7:0]}};
      2'b01:   r = {(NB/2){d[15:0]}};
      2'b10:   r = {(NB/4){d[31:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Shift the addressed lane down and sign- or zero-extend to XLEN.
  function automatic logic [XLEN-1:0] extract(input logic [2:0]      lsel,
                                              input logic [XLEN-1:0] rdat,
                                              input logic [OW-1:0]   off);
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] r;
    lane = rdat >> {off, 3'b000};
    case (lsel)
      3'b000:  r = XLEN'($signed(lane[7:0]));
      3'b001:  r = XLEN'($signed(lane[15:0]));
      3'b010:  r = XLEN'($signed(lane[31:0]));
      3'b011:  r = lane;
      3'b100:  r = XLEN'(lane[7:0]);
      3'b101:  r = XLEN'(lane[15:0]);
      3'b110:  r = XLEN'(lane[31:0]);
      default: r = {XLEN{1'b0}};
    endcase
    return r;
  endfunction

  state_t          state_r;
  state_t          state_nxt;
  logic            is_store_r;
  logic [2:0]      load_sel_r;
  logic [OW-1:0]   off_r;
  logic [4:0]      rd_r;
  logic [CW-1:0]   tmo_cnt_r;

  logic            illegal_s;
  logic [1:0]      size_s;
  logic            tmo_hit_s;
  logic            accept_s;
  logic            issue_hs_s;
  logic            done_s;
  logic            tmo_s;
  logic            resp_hs_s;

  assign illegal_s = is_illegal(req_is_store, load_sel, store_sel, req_addr[2:0]);
  assign size_s    = access_size(req_is_store, load_sel, store_sel);
  assign tmo_hit_s = TMO_EN && (tmo_cnt_r == TMO_LAST);

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state decode and per-cycle event strobes for the datapath.
  always_comb begin
    state_nxt  = state_r;
    accept_s   = 1'b0;
    issue_hs_s = 1'b0;
    done_s     = 1'b0;
    tmo_s      = 1'b0;
    resp_hs_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          accept_s  = 1'b1;
          state_nxt = illegal_s ? ST_RESP : ST_ISSUE;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (tmo_hit_s) begin
          tmo_s     = 1'b1;
          state_nxt = ST_RESP;
        end else if (mem_req_ready) begin
          issue_hs_s = 1'b1;
          state_nxt  = ST_WAIT;
        end else begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        // A response arriving on the expiry cycle still completes normally.
        if (mem_rvalid) begin
          done_s    = 1'b1;
          state_nxt = ST_RESP;
        end else if (tmo_hit_s) begin
          tmo_s     = 1'b1;
          state_nxt = ST_RESP;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          resp_hs_s = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_RESP;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Access timer: cleared on acceptance, counts every ISSUE/WAIT cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmo_cnt_r <= {CW{1'b0}};
    end else if (accept_s) begin
      tmo_cnt_r <= {CW{1'b0}};
    end else if ((state_r == ST_ISSUE) || (state_r == ST_WAIT)) begin
      tmo_cnt_r <= tmo_cnt_r + 1'b1;
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  // Request capture plus registered core- and memory-side outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_ready     <= 1'b1;
      is_store_r    <= 1'b0;
      load_sel_r    <= 3'b000;
      off_r         <= {OW{1'b0}};
      rd_r          <= 5'd0;
      resp_valid    <= 1'b0;
      resp_rd       <= 5'd0;
      resp_data     <= {XLEN{1'b0}};
      resp_err      <= 1'b0;
      resp_err_code <= ERR_NONE;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= {XLEN{1'b0}};
      mem_wdata     <= {XLEN{1'b0}};
      mem_be        <= {NB{1'b0}};
    end else if (accept_s) begin
      req_ready  <= 1'b0;
      is_store_r <= req_is_store;
      load_sel_r <= load_sel;
      off_r      <= req_addr[OW-1:0];
      rd_r       <= req_rd;
      if (illegal_s) begin
        resp_valid    <= 1'b1;
        resp_err      <= 1'b1;
        resp_err_code <= ERR_ILL;
        resp_rd       <= 5'd0;
        resp_data     <= {XLEN{1'b0}};
      end else begin
        mem_req_valid <= 1'b1;
        mem_we        <= req_is_store;
        mem_addr      <= {req_addr[XLEN-1:OW], {OW{1'b0}}};
        mem_be        <= lane_mask(size_s, req_addr[OW-1:0]);
        mem_wdata     <= req_is_store ? replicate(size_s, req_wdata) : {XLEN{1'b0}};
      end
    end else if (tmo_s) begin
      mem_req_valid <= 1'b0;
      resp_valid    <= 1'b1;
      resp_err      <= 1'b1;
      resp_err_code <= ERR_TMO;
      resp_rd       <= 5'd0;
      resp_data     <= {XLEN{1'b0}};
    end else if (issue_hs_s) begin
      mem_req_valid <= 1'b0;
    end else if (done_s) begin
      resp_valid <= 1'b1;
      if (mem_rerr) begin
        resp_err      <= 1'b1;
        resp_err_code <= ERR_BUS;
        resp_rd       <= 5'd0;
        resp_data     <= {XLEN{1'b0}};
      end else if (is_store_r) begin
        resp_err      <= 1'b0;
        resp_err_code <= ERR_NONE;
        resp_rd       <= 5'd0;
        resp_data     <= {XLEN{1'b0}};
      end else begin
        resp_err      <= 1'b0;
        resp_err_code <= ERR_NONE;
        resp_rd       <= rd_r;
        resp_data     <= extract(load_sel_r, mem_rdata, off_r);
      end
    end else if (resp_hs_s) begin
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_err      <= 1'b0;
      resp_err_code <= ERR_NONE;
      resp_rd       <= 5'd0;
      resp_data     <= {XLEN{1'b0}};
    end else begin
      req_ready <= req_ready;
    end
  end

endmodule

// File: tb/tb_iosi_lsu.sv
// Directed bench for iosi_lsu: a 32-bit instance (timeout 8) and a 64-bit
// instance, driven by hand-written steps with hand-computed expectations.
`timescale 1ns/1ps
module tb_iosi_lsu;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // 32-bit instance signals
  logic        a_req_valid = 1'b0, a_req_ready, a_req_is_store = 1'b0;
  logic [2:0]  a_load_sel = 3'b000;
  logic [1:0]  a_store_sel = 2'b00;
  logic [31:0] a_req_addr = 32'h0, a_req_wdata = 32'h0;
  logic [4:0]  a_req_rd = 5'd0;
  logic        a_resp_valid, a_resp_ready = 1'b0;
  logic [4:0]  a_resp_rd;
  logic [31:0] a_resp_data;
  logic        a_resp_err;
  logic [1:0]  a_resp_err_code;
  logic        a_mem_req_valid, a_mem_req_ready = 1'b0, a_mem_we;
  logic [31:0] a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_be;
  logic        a_mem_rvalid = 1'b0, a_mem_rerr = 1'b0;
  logic [31:0] a_mem_rdata = 32'h0;

  // 64-bit instance signals
  logic        b_req_valid = 1'b0, b_req_ready, b_req_is_store = 1'b0;
  logic [2:0]  b_load_sel = 3'b000;
  logic [1:0]  b_store_sel = 2'b00;
  logic [63:0] b_req_addr = 64'h0, b_req_wdata = 64'h0;
  logic [4:0]  b_req_rd = 5'd0;
  logic        b_resp_valid, b_resp_ready = 1'b0;
  logic [4:0]  b_resp_rd;
  logic [63:0] b_resp_data;
  logic        b_resp_err;
  logic [1:0]  b_resp_err_code;
  logic        b_mem_req_valid, b_mem_req_ready = 1'b0, b_mem_we;
  logic [63:0] b_mem_addr, b_mem_wdata;
  logic [7:0]  b_mem_be;
  logic        b_mem_rvalid = 1'b0, b_mem_rerr = 1'b0;
  logic [63:0] b_mem_rdata = 64'h0;

  iosi_lsu #(.XLEN(32), .TIMEOUT_CYCLES(8)) u_a (
    .clk(clk), .resetn(resetn),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_is_store(a_req_is_store),
    .load_sel(a_load_sel), .store_sel(a_store_sel), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata), .req_rd(a_req_rd),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_rd(a_resp_rd),
    .resp_data(a_resp_data), .resp_err(a_resp_err), .resp_err_code(a_resp_err_code),
    .mem_req_valid(a_mem_req_valid), .mem_req_ready(a_mem_req_ready), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_be(a_mem_be),
    .mem_rvalid(a_mem_rvalid), .mem_rdata(a_mem_rdata), .mem_rerr(a_mem_rerr)
  );

  iosi_lsu #(.XLEN(64), .TIMEOUT_CYCLES(64)) u_b (
    .clk(clk), .resetn(resetn),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_is_store(b_req_is_store),
    .load_sel(b_load_sel), .store_sel(b_store_sel), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .req_rd(b_req_rd),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_rd(b_resp_rd),
    .resp_data(b_resp_data), .resp_err(b_resp_err), .resp_err_code(b_resp_err_code),
    .mem_req_valid(b_mem_req_valid), .mem_req_ready(b_mem_req_ready), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_be(b_mem_be),
    .mem_rvalid(b_mem_rvalid), .mem_rdata(b_mem_rdata), .mem_rerr(b_mem_rerr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_issue(input logic st, input logic [2:0] ls, input logic [1:0] ss,
                         input logic [31:0] ad, input logic [31:0] wd, input logic [4:0] rd);
    a_req_valid = 1'b1; a_req_is_store = st; a_load_sel = ls; a_store_sel = ss;
    a_req_addr = ad; a_req_wdata = wd; a_req_rd = rd;
    tick();
    a_req_valid = 1'b0;
  endtask

  task automatic a_ack(input logic [31:0] rdat, input logic rerr);
    tick();
    a_mem_rvalid = 1'b1; a_mem_rdata = rdat; a_mem_rerr = rerr;
    tick();
    a_mem_rvalid = 1'b0; a_mem_rerr = 1'b0;
  endtask

  task automatic a_finish();
    a_resp_ready = 1'b1;
    tick();
    a_resp_ready = 1'b0;
  endtask

  task automatic b_issue(input logic st, input logic [2:0] ls, input logic [1:0] ss,
                         input logic [63:0] ad, input logic [63:0] wd, input logic [4:0] rd);
    b_req_valid = 1'b1; b_req_is_store = st; b_load_sel = ls; b_store_sel = ss;
    b_req_addr = ad; b_req_wdata = wd; b_req_rd = rd;
    tick();
    b_req_valid = 1'b0;
  endtask

  task automatic b_ack(input logic [63:0] rdat, input logic rerr);
    tick();
    b_mem_rvalid = 1'b1; b_mem_rdata = rdat; b_mem_rerr = rerr;
    tick();
    b_mem_rvalid = 1'b0; b_mem_rerr = 1'b0;
  endtask

  task automatic b_finish();
    b_resp_ready = 1'b1;
    tick();
    b_resp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_req_ready", a_req_ready, 1'b1);
    chk("rst_resp_valid", a_resp_valid, 1'b0);
    chk("rst_mem_req_valid", a_mem_req_valid, 1'b0);
    chk("rst_mem_be", a_mem_be, 4'h0);
    chk("rst_b_req_ready", b_req_ready, 1'b1);
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // LB / LBU at byte offset 3, zero-wait memory
    a_mem_req_ready = 1'b1;
    a_issue(1'b0, 3'b000, 2'b00, 32'h1003, 32'h0, 5'd5);
    chk("lb_mem_valid", a_mem_req_valid, 1'b1);
    chk("lb_mem_addr", a_mem_addr, 32'h1000);
    chk("lb_mem_be", a_mem_be, 4'h8);
    chk("lb_mem_we", a_mem_we, 1'b0);
    chk("lb_req_ready_busy", a_req_ready, 1'b0);
    a_ack(32'h8000_0000, 1'b0);
    chk("lb_resp_valid", a_resp_valid, 1'b1);
    chk("lb_resp_data", a_resp_data, 32'hFFFF_FF80);
    chk("lb_resp_rd", a_resp_rd, 5'd5);
    chk("lb_resp_err", a_resp_err, 1'b0);
    a_finish();
    chk("lb_req_ready_after", a_req_ready, 1'b1);
    chk("lb_resp_valid_after", a_resp_valid, 1'b0);
    a_issue(1'b0, 3'b100, 2'b00, 32'h1003, 32'h0, 5'd6);
    a_ack(32'h8000_0000, 1'b0);
    chk("lbu_resp_data", a_resp_data, 32'h0000_0080);
    chk("lbu_resp_rd", a_resp_rd, 5'd6);
    a_finish();

    // SH with mem_req_ready low for 3 ISSUE cycles
    a_mem_req_ready = 1'b0;
    a_issue(1'b1, 3'b000, 2'b01, 32'h2002, 32'hABCD_1234, 5'd7);
    for (int i = 0; i < 4; i++) begin
      chk("sh_mem_valid", a_mem_req_valid, 1'b1);
      chk("sh_mem_wdata", a_mem_wdata, 32'h1234_1234);
      chk("sh_mem_be", a_mem_be, 4'hC);
      chk("sh_mem_addr", a_mem_addr, 32'h2000);
      chk("sh_mem_we", a_mem_we, 1'b1);
      if (i < 3) tick();
    end
    a_mem_req_ready = 1'b1;
    a_ack(32'h0, 1'b0);
    chk("sh_resp_valid", a_resp_valid, 1'b1);
    chk("sh_resp_err", a_resp_err, 1'b0);
    chk("sh_resp_rd", a_resp_rd, 5'd0);
    a_finish();

    // Misaligned LW and LD on a 32-bit datapath
    a_issue(1'b0, 3'b010, 2'b00, 32'h3001, 32'h0, 5'd9);
    chk("lw_mis_mem_valid", a_mem_req_valid, 1'b0);
    chk("lw_mis_resp_valid", a_resp_valid, 1'b1);
    chk("lw_mis_err", a_resp_err, 1'b1);
    chk("lw_mis_code", a_resp_err_code, 2'b01);
    chk("lw_mis_data", a_resp_data, 32'h0);
    chk("lw_mis_rd", a_resp_rd, 5'd0);
    a_finish();
    a_issue(1'b0, 3'b011, 2'b00, 32'h1000, 32'h0, 5'd9);
    chk("ld32_mem_valid", a_mem_req_valid, 1'b0);
    chk("ld32_resp_valid", a_resp_valid, 1'b1);
    chk("ld32_code", a_resp_err_code, 2'b01);
    chk("ld32_data", a_resp_data, 32'h0);
    a_finish();

    // Timeout after 8 cycles, late response ignored, next op normal
    a_issue(1'b0, 3'b010, 2'b00, 32'h5000, 32'h0, 5'd3);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("tmo_not_yet", a_resp_valid, 1'b0);
    end
    tick();
    chk("tmo_resp_valid", a_resp_valid, 1'b1);
    chk("tmo_code", a_resp_err_code, 2'b11);
    chk("tmo_err", a_resp_err, 1'b1);
    chk("tmo_mem_valid", a_mem_req_valid, 1'b0);
    a_mem_rvalid = 1'b1; a_mem_rdata = 32'hDEAD_BEEF;
    tick();
    a_mem_rvalid = 1'b0;
    chk("tmo_late_data", a_resp_data, 32'h0);
    chk("tmo_late_code", a_resp_err_code, 2'b11);
    a_finish();
    a_mem_rvalid = 1'b1;
    tick();
    a_mem_rvalid = 1'b0;
    chk("idle_rvalid_resp", a_resp_valid, 1'b0);
    chk("idle_rvalid_ready", a_req_ready, 1'b1);
    a_issue(1'b0, 3'b010, 2'b00, 32'h5004, 32'h0, 5'd4);
    a_ack(32'h1234_5678, 1'b0);
    chk("after_tmo_data", a_resp_data, 32'h1234_5678);
    chk("after_tmo_err", a_resp_err, 1'b0);
    chk("after_tmo_rd", a_resp_rd, 5'd4);
    a_finish();

    // Response held while resp_ready is low
    a_issue(1'b0, 3'b001, 2'b00, 32'h6002, 32'h0, 5'd12);
    a_ack(32'h8001_0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_resp_valid", a_resp_valid, 1'b1);
      chk("hold_resp_data", a_resp_data, 32'hFFFF_8001);
      chk("hold_resp_rd", a_resp_rd, 5'd12);
      chk("hold_req_ready", a_req_ready, 1'b0);
      tick();
    end
    a_finish();
    chk("hold_req_ready_after", a_req_ready, 1'b1);

    // Asynchronous reset while waiting for memory
    a_issue(1'b0, 3'b010, 2'b00, 32'h7000, 32'h0, 5'd2);
    tick();
    chk("pre_rst_addr", a_mem_addr, 32'h7000);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_req_ready", a_req_ready, 1'b1);
    chk("async_rst_mem_addr", a_mem_addr, 32'h0);
    chk("async_rst_resp_valid", a_resp_valid, 1'b0);
    a_mem_rvalid = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    tick();
    chk("post_rst_resp_valid", a_resp_valid, 1'b0);
    chk("post_rst_req_ready", a_req_ready, 1'b1);
    a_mem_rvalid = 1'b0;
    tick();

    // 64-bit datapath: LWU, LW, SW lane steering, bus error
    b_mem_req_ready = 1'b1;
    b_issue(1'b0, 3'b110, 2'b00, 64'h4004, 64'h0, 5'd8);
    chk("lwu_mem_be", b_mem_be, 8'hF0);
    chk("lwu_mem_addr", b_mem_addr, 64'h4000);
    b_ack(64'hF000_0000_0000_0000, 1'b0);
    chk("lwu_resp_data", b_resp_data, 64'h0000_0000_F000_0000);
    chk("lwu_resp_rd", b_resp_rd, 5'd8);
    b_finish();
    b_issue(1'b0, 3'b010, 2'b00, 64'h4004, 64'h0, 5'd8);
    b_ack(64'hF000_0000_0000_0000, 1'b0);
    chk("lw64_resp_data", b_resp_data, 64'hFFFF_FFFF_F000_0000);
    b_finish();
    b_issue(1'b1, 3'b000, 2'b10, 64'h4004, 64'h0000_0000_1122_3344, 5'd8);
    chk("sw64_mem_wdata", b_mem_wdata, 64'h1122_3344_1122_3344);
    chk("sw64_mem_be", b_mem_be, 8'hF0);
    chk("sw64_mem_we", b_mem_we, 1'b1);
    b_ack(64'h0, 1'b0);
    chk("sw64_resp_rd", b_resp_rd, 5'd0);
    b_finish();
    b_issue(1'b0, 3'b011, 2'b00, 64'h4008, 64'h0, 5'd10);
    chk("ld64_mem_be", b_mem_be, 8'hFF);
    chk("ld64_mem_addr", b_mem_addr, 64'h4008);
    b_ack(64'hAAAA_BBBB_CCCC_DDDD, 1'b1);
    chk("berr_resp_err", b_resp_err, 1'b1);
    chk("berr_code", b_resp_err_code, 2'b10);
    chk("berr_data", b_resp_data, 64'h0);
    chk("berr_rd", b_resp_rd, 5'd0);
    b_finish();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iosi_lsu.md
Name: iosi_lsu

Overview:
- Parametrised load/store unit for the in-order single-issue pipeline.
- Replaces the fixed 32-bit, always-ready memory stage path. Adds:
  - XLEN-generic byte-lane steering
  - valid/ready handshakes on the core and memory sides
  - variable memory latency
  - misalignment, bus-error and timeout reporting
- Sits between execute and writeback; drives the data-memory port.

Parameters:
- XLEN, 32, datapath/address width; legal values 32 or 64 (64 enables LD/LWU/SD).
- TIMEOUT_CYCLES, 64, max cycles in ISSUE+WAIT before abort; 0 disables timeout.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  LSU can accept a request
- req_is_store  in  1  1=store, 0=load
- load_sel  in  3  RISC-V funct3: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU
- store_sel  in  2  00 SB, 01 SH, 10 SW, 11 SD
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, right-justified
- req_rd  in  5  destination register
- resp_valid  out  1  response valid
- resp_ready  in  1  writeback accepts response
- resp_rd  out  5  destination register; 0 for stores and errors
- resp_data  out  XLEN  extended load data; 0 for stores and errors
- resp_err  out  1  error flag
- resp_err_code  out  2  00 none, 01 misaligned/illegal, 10 bus error, 11 timeout
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_we  out  1  write enable
- mem_addr  out  XLEN  address aligned to XLEN/8
- mem_wdata  out  XLEN  lane-replicated store data
- mem_be  out  XLEN/8  byte enables
- mem_rvalid  in  1  read data / write ack valid
- mem_rdata  in  XLEN  read data
- mem_rerr  in  1  bus error, qualified by mem_rvalid

Behaviour:

Reset:
- Clock is clk; reset is asynchronous, active-low (resetn).
- On reset: state=IDLE. All outputs are 0 except req_ready=1. Timeout counter and captured request are cleared.

State machine (IDLE, ISSUE, WAIT, RESP):
- req_ready=1 only in IDLE. A request is accepted on req_valid&&req_ready and all fields are captured into registers.
- IDLE -> RESP when the accepted request is illegal. No memory access occurs; err_code=01. Illegal means either:
  - misaligned: H needs addr[0]=0; W needs addr[1:0]=0; D needs addr[2:0]=0
  - a 64-bit op (LD, LWU, SD) or load_sel=111 when XLEN=32
- IDLE -> ISSUE for a legal request. mem_req_valid rises the cycle after acceptance (one-cycle minimum latency to memory).
- In ISSUE, mem_req_valid and all mem_* outputs are held stable until mem_req_ready. Then -> WAIT.
- In WAIT, the first mem_rvalid ends the access -> RESP.
  - Loads capture the extended data.
  - If mem_rerr=1, err_code=10 and data is discarded.
  - Stores also wait for mem_rvalid as the write acknowledge.
- mem_rvalid outside WAIT is ignored.
- In RESP, resp_valid=1 and all resp_* outputs are stable until resp_ready. Then -> IDLE.
  - req_ready rises the cycle after the handshake. There is no same-cycle accept, so throughput is at most one op per 4 cycles with zero-wait memory.

Timeout:
- The counter resets on entry to ISSUE and increments each cycle in ISSUE or WAIT.
- When it reaches TIMEOUT_CYCLES (nonzero): -> RESP with err_code=11, mem_req_valid drops immediately (abort), and any later mem_rvalid is ignored.
- If mem_rvalid and timeout expire in the same cycle, mem_rvalid wins.

Lane steering (N=XLEN/8, off=addr[log2(N)-1:0]):
- mem_addr = addr with its low log2(N) bits zeroed.
- Store masks: SB 1, SH 3, SW 0xF, SD 0xFF; mem_be = mask << off.
- Store data: mem_wdata replicates the low byte/half/word across the bus.
- Load data: lane = mem_rdata >> (8*off), truncated to the access size. Signed ops sign-extend to XLEN; U ops zero-extend. LW sign-extends on XLEN=64.
- Loads: mem_we=0, mem_be is the same mask as the store case.

Reset mid-operation:
- Reset returns to IDLE immediately. Any outstanding memory response is dropped with no response.

Test Plan:
1. XLEN=32, LB addr=0x1003, mem_rdata=0x80_00_00_00 with zero wait -> mem_addr=0x1000, mem_be=0x8; resp_data=0xFFFFFF80, resp_rd=req_rd, err=0. Same with LBU -> 0x00000080.
2. XLEN=32, SH addr=0x2002, wdata=0xABCD1234; mem_req_ready low 3 cycles -> mem_wdata=0x12341234, mem_be=0xC, all mem_* stable for all 4 ISSUE cycles; resp_err=0, resp_rd=0.
3. LW addr=0x3001 -> no mem_req_valid ever asserted; resp_err=1, code=01, resp_data=0; with XLEN=32, LD at any address -> same response.
4. TIMEOUT_CYCLES=8, memory never asserts mem_rvalid -> resp_valid 8 cycles after ISSUE entry, code=11; a late mem_rvalid is ignored and the next request completes normally.
5. XLEN=64, LWU addr=0x4004, mem_rdata=0xF0000000_00000000 -> mem_be=0xF0, resp_data=0x00000000F0000000; LW -> 0xFFFFFFFFF0000000; mem_rerr=1 on mem_rvalid -> code=10.
6. resp_ready held low 5 cycles -> resp_* stable, req_ready=0 throughout; resetn pulsed in WAIT -> all outputs at reset values asynchronously, req_ready=1 after release.
